// File: rtl/ahb_gpio_if.sv
// AHB-Lite bus bundle between the bus matrix (master side) and the GPIO
// controller (slave side).
interface ahb_gpio_if #(
  parameter int ADDR_W = 12
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  // Handshake: a transfer is accepted in its address phase when HSEL, HREADY
  // and HTRANS[1] are all high; its data phase is the following cycle, and
  // HREADYOUT is always high so every data phase completes in that one cycle.
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_gpio.sv
// AHB-Lite GPIO controller: output data/enable registers, synchronized input,
// per-bit rising/falling edge capture and a level interrupt.
module ahb_gpio #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic             CLK,
  input  logic             PORESETn,
  ahb_gpio_if.slave        bus,
  input  logic [WIDTH-1:0] GPIO_I,
  output logic [WIDTH-1:0] GPIO_O,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);
  localparam logic [2:0] OFF_DOUT = 3'd0;
  localparam logic [2:0] OFF_OE   = 3'd1;
  localparam logic [2:0] OFF_DIN  = 3'd2;
  localparam logic [2:0] OFF_RISE = 3'd3;
  localparam logic [2:0] OFF_FALL = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_SET  = 3'd6;
  localparam logic [2:0] OFF_CLR  = 3'd7;

  logic              accept;
  logic              wr_pend;
  logic              rd_pend;
  logic [ADDR_W-3:0] addr_q;
  logic              map_hit;
  logic [2:0]        reg_sel;

  logic [WIDTH-1:0]  dout, oe, rise_en, fall_en, stat;
  logic [WIDTH-1:0]  sync1, sync2, prev;
  logic [WIDTH-1:0]  wdata, rise, fall, w1c, stat_next, rd_val;
  logic              unused_bus;

  assign accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign map_hit = (addr_q >> 3) == '0;
  assign reg_sel = addr_q[2:0];
  assign wdata   = bus.HWDATA[WIDTH-1:0];

  // Size and byte-lane bits carry no meaning: every access is a word access.
  assign unused_bus = ^{bus.HSIZE, bus.HADDR[1:0], bus.HWDATA};

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      addr_q  <= '0;
    end else begin
      wr_pend <= accept & bus.HWRITE;
      rd_pend <= accept & ~bus.HWRITE;
      if (accept) addr_q <= bus.HADDR[ADDR_W-1:2];
    end
  end

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      dout    <= '0;
      oe      <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_pend && map_hit) begin
      case (reg_sel)
        OFF_DOUT: dout    <= wdata;
        OFF_OE:   oe      <= wdata;
        OFF_RISE: rise_en <= wdata;
        OFF_FALL: fall_en <= wdata;
        OFF_SET:  dout    <= dout | wdata;
        OFF_CLR:  dout    <= dout & ~wdata;
        default:  ;
      endcase
    end
  end

  // Two-flop synchronizer, plus one more stage to detect edges on clean data.
  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= GPIO_I;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;
  assign w1c  = (wr_pend && map_hit && reg_sel == OFF_STAT) ? wdata : '0;

  // A new edge overrides a simultaneous write-one-to-clear of the same bit.
  assign stat_next = (stat & ~w1c) | (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) stat <= '0;
    else           stat <= stat_next;
  end

  always_comb begin
    rd_val = '0;
    if (map_hit) begin
      case (reg_sel)
        OFF_DOUT: rd_val = dout;
        OFF_OE:   rd_val = oe;
        OFF_DIN:  rd_val = sync2;
        OFF_RISE: rd_val = rise_en;
        OFF_FALL: rd_val = fall_en;
        OFF_STAT: rd_val = stat;
        default:  rd_val = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rd_pend ? 32'(rd_val) : 32'h0;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  assign GPIO_O  = dout;
  assign GPIO_OE = oe;
  assign IRQ     = |stat;
endmodule

// File: tb/tb_ahb_gpio.sv
// Bench for ahb_gpio: directed scenarios plus randomized register traffic,
// checked against a register-map model kept in the bench.
module tb_ahb_gpio;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] A_DOUT = 12'h000;
  localparam logic [ADDR_W-1:0] A_OE   = 12'h004;
  localparam logic [ADDR_W-1:0] A_DIN  = 12'h008;
  localparam logic [ADDR_W-1:0] A_RISE = 12'h00C;
  localparam logic [ADDR_W-1:0] A_FALL = 12'h010;
  localparam logic [ADDR_W-1:0] A_STAT = 12'h014;
  localparam logic [ADDR_W-1:0] A_SET  = 12'h018;
  localparam logic [ADDR_W-1:0] A_CLR  = 12'h01C;
  localparam logic [ADDR_W-1:0] A_HOLE = 12'h040;

  logic             CLK = 1'b0;
  logic             PORESETn;
  logic [WIDTH-1:0] GPIO_I;
  logic [WIDTH-1:0] GPIO_O;
  logic [WIDTH-1:0] GPIO_OE;
  logic             IRQ;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] m_dout, m_oe, m_rise, m_fall, m_stat, m_pad;

  ahb_gpio_if #(.ADDR_W(ADDR_W)) bus ();

  ahb_gpio #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .PORESETn(PORESETn), .bus(bus),
    .GPIO_I(GPIO_I), .GPIO_O(GPIO_O), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic model_clear();
    m_dout = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_stat = '0;
  endtask

  task automatic do_reset();
    PORESETn = 1'b0;
    repeat (2) tick();
    PORESETn = 1'b1;
    model_clear();
    repeat (3) tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_phase();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HREADY = 1'b1;
  endtask

  task automatic addr_phase(input logic wr, input logic [ADDR_W-1:0] a);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = a;
    bus.HSIZE = 3'($urandom_range(0, 2)); bus.HREADY = 1'b1;
  endtask

  task automatic ahb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    tick();
    idle_phase();
    bus.HWDATA = d;
    tick();
  endtask

  task automatic ahb_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    addr_phase(1'b0, a);
    tick();
    idle_phase();
    d = bus.HRDATA;
  endtask

  // Write-looking transfer that must not be accepted (mode picks the reason).
  task automatic ignored_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int mode);
    addr_phase(1'b1, a);
    case (mode)
      0:       bus.HTRANS = 2'($urandom_range(0, 1));
      1:       bus.HSEL = 1'b0;
      default: bus.HREADY = 1'b0;
    endcase
    tick();
    idle_phase();
    bus.HWDATA = d;
    tick();
  endtask

  task automatic set_pad(input logic [WIDTH-1:0] v, input int settle);
    GPIO_I = v;
    m_pad  = v;
    repeat (settle) tick();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int w;
    w = int'(a[ADDR_W-1:2]);
    case (w)
      0:       return 32'(m_dout);
      1:       return 32'(m_oe);
      2:       return 32'(m_pad);
      3:       return 32'(m_rise);
      4:       return 32'(m_fall);
      5:       return 32'(m_stat);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int w;
    logic [WIDTH-1:0] v;
    w = int'(a[ADDR_W-1:2]);
    v = d[WIDTH-1:0];
    case (w)
      0: m_dout = v;
      1: m_oe   = v;
      3: m_rise = v;
      4: m_fall = v;
      5: m_stat = m_stat & ~v;
      6: m_dout = m_dout | v;
      7: m_dout = m_dout & ~v;
      default: ;
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ahb_read(ADDR_W'(i * 4), d);
      n_checks++; if (d !== 32'h0) $display("FAIL reset_read off=%0h: got %0h exp 0", i * 4, d); else n_pass++;
    end
    tick();
    n_checks++; if (GPIO_O !== '0) $display("FAIL reset_gpio_o: got %0h exp 0", GPIO_O); else n_pass++;
    n_checks++; if (GPIO_OE !== '0) $display("FAIL reset_gpio_oe: got %0h exp 0", GPIO_OE); else n_pass++;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %0b exp 0", IRQ); else n_pass++;
    n_checks++; if (bus.HRDATA !== 32'h0) $display("FAIL idle_hrdata: got %0h exp 0", bus.HRDATA); else n_pass++;
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0)
      $display("FAIL bus_resp: got readyout=%0b resp=%0b exp 1/0", bus.HREADYOUT, bus.HRESP); else n_pass++;
  endtask

  task automatic test_dout_oe();
    logic [31:0] d;
    ahb_write(A_DOUT, 32'hFFFF_FFA5); model_write(A_DOUT, 32'hA5);
    ahb_write(A_OE, 32'h0F);          model_write(A_OE, 32'h0F);
    n_checks++; if (GPIO_O !== 8'hA5) $display("FAIL dout_pins: got %0h exp a5", GPIO_O); else n_pass++;
    n_checks++; if (GPIO_OE !== 8'h0F) $display("FAIL oe_pins: got %0h exp 0f", GPIO_OE); else n_pass++;
    ahb_read(A_DOUT, d);
    n_checks++; if (d !== 32'hA5) $display("FAIL dout_read: got %0h exp a5", d); else n_pass++;
    ahb_read(A_OE, d);
    n_checks++; if (d !== 32'h0F) $display("FAIL oe_read: got %0h exp 0f", d); else n_pass++;
    ahb_write(A_SET, 32'h02); model_write(A_SET, 32'h02);
    ahb_read(A_DOUT, d);
    n_checks++; if (d !== 32'hA7) $display("FAIL dout_set: got %0h exp a7", d); else n_pass++;
    ahb_write(A_CLR, 32'h80); model_write(A_CLR, 32'h80);
    ahb_read(A_DOUT, d);
    n_checks++; if (d !== 32'h27) $display("FAIL dout_clr: got %0h exp 27", d); else n_pass++;
    ahb_read(A_SET, d);
    n_checks++; if (d !== 32'h0) $display("FAIL set_reads_zero: got %0h exp 0", d); else n_pass++;
    ahb_read(A_CLR, d);
    n_checks++; if (d !== 32'h0) $display("FAIL clr_reads_zero: got %0h exp 0", d); else n_pass++;
  endtask

  task automatic test_random_regs();
    logic [31:0] d, exp;
    logic [ADDR_W-1:0] a;
    int idx, kind;
    set_pad(WIDTH'($urandom), 4);
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 9);
      if (idx < 8)       a = ADDR_W'(idx * 4);
      else if (idx == 8) a = A_HOLE;
      else               a = ADDR_W'($urandom_range(8, 1023) * 4);
      a = a | ADDR_W'($urandom_range(0, 3));
      d = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        ahb_write(a, d);
        model_write(a, d);
      end else if (kind < 9) begin
        ahb_read(a, d);
        exp = model_read(a);
        n_checks++; if (d !== exp) $display("FAIL rand_read addr=%0h: got %0h exp %0h", a, d, exp); else n_pass++;
      end else begin
        ignored_write(a, d, $urandom_range(0, 2));
      end
      n_checks++; if (GPIO_O !== m_dout) $display("FAIL rand_gpio_o op=%0d: got %0h exp %0h", i, GPIO_O, m_dout); else n_pass++;
      n_checks++; if (GPIO_OE !== m_oe) $display("FAIL rand_gpio_oe op=%0d: got %0h exp %0h", i, GPIO_OE, m_oe); else n_pass++;
    end
    ahb_write(A_RISE, 32'h0); model_write(A_RISE, 32'h0);
    ahb_write(A_FALL, 32'h0); model_write(A_FALL, 32'h0);
  endtask

  task automatic test_rise_edge();
    logic [31:0] d;
    logic [WIDTH-1:0] mb;
    mb = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
    set_pad(m_pad & ~mb, 4);
    ahb_write(A_RISE, 32'(mb)); model_write(A_RISE, 32'(mb));
    // Pad rises before edge k; DIN follows after k+1, STAT/IRQ after k+2.
    GPIO_I = m_pad | mb;
    addr_phase(1'b0, A_DIN);
    tick();
    d = bus.HRDATA;
    n_checks++; if (d !== 32'(m_pad)) $display("FAIL din_early: got %0h exp %0h", d, m_pad); else n_pass++;
    addr_phase(1'b0, A_DIN);
    tick();
    m_pad = m_pad | mb;
    d = bus.HRDATA;
    idle_phase();
    n_checks++; if (d !== 32'(m_pad)) $display("FAIL din_latency: got %0h exp %0h", d, m_pad); else n_pass++;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL irq_early: got %0b exp 0", IRQ); else n_pass++;
    tick();
    m_stat = m_stat | mb;
    n_checks++; if (IRQ !== 1'b1) $display("FAIL irq_rise: got %0b exp 1", IRQ); else n_pass++;
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'(m_stat)) $display("FAIL stat_rise: got %0h exp %0h", d, m_stat); else n_pass++;
    ahb_write(A_STAT, 32'(mb)); model_write(A_STAT, 32'(mb));
    n_checks++; if (IRQ !== 1'b0) $display("FAIL irq_w1c: got %0b exp 0", IRQ); else n_pass++;
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0) $display("FAIL stat_w1c: got %0h exp 0", d); else n_pass++;
    ahb_write(A_RISE, 32'h0); model_write(A_RISE, 32'h0);
  endtask

  task automatic test_fall_edge();
    logic [31:0] d;
    logic [WIDTH-1:0] mb;
    mb = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
    set_pad(m_pad & ~mb, 4);
    ahb_write(A_FALL, 32'(mb)); model_write(A_FALL, 32'(mb));
    set_pad(m_pad | mb, 4);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0) $display("FAIL fall_ignores_rise: got %0h exp 0", d); else n_pass++;
    set_pad(m_pad & ~mb, 4);
    m_stat = m_stat | mb;
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'(m_stat)) $display("FAIL stat_fall: got %0h exp %0h", d, m_stat); else n_pass++;
    n_checks++; if (IRQ !== 1'b1) $display("FAIL irq_fall: got %0b exp 1", IRQ); else n_pass++;
    // Dropping the enable keeps the captured flag; edges seen meanwhile are lost.
    ahb_write(A_FALL, 32'h0); model_write(A_FALL, 32'h0);
    set_pad(m_pad | mb, 4);
    set_pad(m_pad & ~mb, 4);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'(m_stat)) $display("FAIL stat_kept: got %0h exp %0h", d, m_stat); else n_pass++;
    ahb_write(A_STAT, 32'(mb)); model_write(A_STAT, 32'(mb));
    ahb_write(A_FALL, 32'(mb)); model_write(A_FALL, 32'(mb));
    repeat (3) tick();
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'h0) $display("FAIL stat_not_remembered: got %0h exp 0", d); else n_pass++;
    ahb_write(A_FALL, 32'h0); model_write(A_FALL, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    set_pad(m_pad & ~WIDTH'(1), 4);
    ahb_write(A_RISE, 32'h1); model_write(A_RISE, 32'h1);
    set_pad(m_pad | WIDTH'(1), 4);
    set_pad(m_pad & ~WIDTH'(1), 4);
    m_stat = m_stat | WIDTH'(1);
    // The W1C commits on the same edge the new rise is captured.
    GPIO_I = m_pad | WIDTH'(1);
    tick();
    addr_phase(1'b1, A_STAT);
    tick();
    idle_phase();
    bus.HWDATA = 32'h1;
    tick();
    m_pad = m_pad | WIDTH'(1);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'(m_stat)) $display("FAIL collision_set_wins: got %0h exp %0h", d, m_stat); else n_pass++;
    ahb_write(A_STAT, 32'h1); model_write(A_STAT, 32'h1);
    ahb_read(A_STAT, d);
    n_checks++; if (d !== 32'(m_stat)) $display("FAIL collision_clear_after: got %0h exp %0h", d, m_stat); else n_pass++;
    ahb_write(A_RISE, 32'h0); model_write(A_RISE, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    addr_phase(1'b1, A_OE);
    tick();
    bus.HWDATA = 32'h3C;
    addr_phase(1'b0, A_OE);
    tick();
    d = bus.HRDATA;
    idle_phase();
    model_write(A_OE, 32'h3C);
    n_checks++; if (d !== 32'h3C) $display("FAIL b2b_read: got %0h exp 3c", d); else n_pass++;
    n_checks++; if (GPIO_OE !== m_oe) $display("FAIL b2b_pins: got %0h exp %0h", GPIO_OE, m_oe); else n_pass++;
    tick();
  endtask

  task automatic test_bus_corners();
    logic [31:0] d, exp;
    ahb_write(A_HOLE, 32'hFFFF_FFFF);
    ahb_read(A_HOLE, d);
    n_checks++; if (d !== 32'h0) $display("FAIL hole_read: got %0h exp 0", d); else n_pass++;
    for (int m = 0; m < 3; m++) begin
      ignored_write(A_DOUT, 32'(~m_dout), m);
      ignored_write(A_OE, 32'(~m_oe), m);
    end
    for (int i = 0; i < 6; i++) begin
      ahb_read(ADDR_W'(i * 4), d);
      exp = model_read(ADDR_W'(i * 4));
      n_checks++; if (d !== exp) $display("FAIL no_side_effect off=%0h: got %0h exp %0h", i * 4, d, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    ahb_write(A_DOUT, 32'hC3); model_write(A_DOUT, 32'hC3);
    ahb_write(A_OE, 32'hF0);   model_write(A_OE, 32'hF0);
    addr_phase(1'b1, A_DOUT);
    tick();
    idle_phase();
    bus.HWDATA = 32'hFF;
    #1 PORESETn = 1'b0;
    #1;
    n_checks++; if (GPIO_O !== '0 || GPIO_OE !== '0 || IRQ !== 1'b0)
      $display("FAIL mid_reset_outputs: got o=%0h oe=%0h irq=%0b exp 0", GPIO_O, GPIO_OE, IRQ); else n_pass++;
    n_checks++; if (bus.HRDATA !== 32'h0) $display("FAIL mid_reset_hrdata: got %0h exp 0", bus.HRDATA); else n_pass++;
    #1 PORESETn = 1'b1;
    model_clear();
    tick();
    n_checks++; if (GPIO_O !== '0) $display("FAIL dropped_write: got %0h exp 0", GPIO_O); else n_pass++;
    repeat (3) tick();
    ahb_read(A_DOUT, d);
    n_checks++; if (d !== 32'h0) $display("FAIL post_reset_dout: got %0h exp 0", d); else n_pass++;
    ahb_read(A_DIN, d);
    n_checks++; if (d !== 32'(m_pad)) $display("FAIL post_reset_din: got %0h exp %0h", d, m_pad); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    PORESETn   = 1'b0;
    GPIO_I     = '0;
    m_pad      = '0;
    bus.HADDR  = '0;
    bus.HSIZE  = 3'd2;
    bus.HWDATA = 32'h0;
    idle_phase();
    model_clear();
    test_reset();
    test_dout_oe();
    test_random_regs();
    test_rise_edge();
    test_fall_edge();
    test_collision();
    test_back_to_back();
    test_bus_corners();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ahb_gpio.md
Name: ahb_gpio

Overview:
- AHB-Lite slave GPIO controller inside the minimal CM3 SoC.
- Sits between the bus matrix and the GPIO_O / GPIO_OE / GPIO_I pins that the FPGA top turns into tristate pads.
- Provides output data and output-enable registers, a synchronized input register, and per-bit rising/falling edge interrupt capture.
- Drives a single level interrupt to the NVIC.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- ADDR_W, 12, number of HADDR bits decoded. Registers sit at word offsets within this window.

Ports:
- CLK  in  1  system clock (HCLK domain).
- PORESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; ignored, all accesses are treated as word accesses.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADY  in  1  bus ready (previous transfer is complete).
- HRDATA  out  32  read data, valid in the data phase.
- HREADYOUT  out  1  constant 1 (zero wait states).
- HRESP  out  1  constant 0 (OKAY).
- GPIO_I  in  WIDTH  raw pad inputs, asynchronous to CLK.
- GPIO_O  out  WIDTH  output data to the pads.
- GPIO_OE  out  WIDTH  per-bit output enable, 1 = drive.
- IRQ  out  1  level interrupt, high while any enabled status bit is set.

Behaviour:
- Clock and reset: one clock, CLK. Reset is PORESETn, asynchronous assert, active-low. Every flop clears to 0 on reset.
- Reset values: HRDATA = 0, GPIO_O = 0, GPIO_OE = 0 (pads float), IRQ = 0, both synchronizer stages and prev = 0.
- Register map (offset = HADDR[ADDR_W-1:2]*4; only bits [WIDTH-1:0] exist, upper bits read 0):
  - 0x00 DOUT, RW. Drives GPIO_O directly.
  - 0x04 OE, RW. Drives GPIO_OE directly.
  - 0x08 DIN, RO. Synchronized input value.
  - 0x0C RISE_EN, RW. Per-bit rising-edge capture enable.
  - 0x10 FALL_EN, RW. Per-bit falling-edge capture enable.
  - 0x14 STAT, W1C. Captured edge flags.
  - 0x18 DOUT_SET. Write 1s to set DOUT bits; reads 0.
  - 0x1C DOUT_CLR. Write 1s to clear DOUT bits; reads 0.
  - Other offsets read 0; writes to them are ignored.
- Address phase:
  - A transfer is accepted when HSEL & HREADY & HTRANS[1].
  - On acceptance, register the write flag and word offset. Otherwise clear the pending-access flag.
- Data phase write:
  - At the next CLK edge, apply HWDATA[WIDTH-1:0] to the latched offset.
  - The register updates at the edge ending the data phase.
- Data phase read:
  - HRDATA is driven from the current register value during the data phase (combinational mux of the latched offset).
  - HRDATA = 0 when no read is pending.
  - A read issued immediately after a write to the same register returns the new value.
- Input synchronizer:
  - Chain: sync1 <= GPIO_I; sync2 <= sync1; prev <= sync2.
  - DIN = sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- Latency (pad changes before edge k):
  - DIN reflects the change after edge k+1.
  - STAT bit sets at edge k+2; IRQ goes high in the cycle after edge k+2.
- STAT update per bit: next = (stat & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
- Edge enables:
  - Clearing an enable does not clear an already captured STAT bit.
  - Edges that occur while the enable is 0 are not remembered.
- IRQ = |STAT (registered state, no combinational path from the pads).
- Reset mid-transfer: the pending access is dropped and all registers clear. No write completes after PORESETn deasserts until a new address phase is accepted.
- Idle transfers: HTRANS IDLE/BUSY or HSEL=0 cause no register side effects.

Test Plan:
- Reset values: after reset, read offsets 0x00–0x1C -> all return 0; GPIO_OE = 0x00; IRQ = 0.
- DOUT / OE and set/clear:
  - Write DOUT = 0xA5 and OE = 0x0F -> GPIO_O = 0xA5 after the data-phase edge, GPIO_OE = 0x0F; readback matches.
  - Then write DOUT_SET = 0x02 -> DOUT reads 0xA7.
  - Then write DOUT_CLR = 0x80 -> DOUT reads 0x27.
- Input sync and rising edge:
  - Set RISE_EN = 0x01; drive GPIO_I[0] 0->1 before edge k -> DIN bit 0 = 1 after k+1, STAT = 0x01 at k+2, IRQ = 1.
  - Write STAT = 0x01 -> IRQ = 0 on the next cycle.
- Falling edge and enable gating:
  - FALL_EN = 0x04, RISE_EN = 0; toggle GPIO_I[2] 0->1->0 -> only one STAT bit 2 is set, captured on the 1->0 transition.
- Collision: W1C of STAT bit 0 in the same cycle as a new rise on bit 0 -> STAT bit 0 remains 1.
- Bus corners:
  - Back-to-back write then read of OE = 0x3C -> read returns 0x3C.
  - Access to offset 0x40 -> reads 0, no state change.
  - HTRANS = IDLE with HWRITE = 1 -> no register change.
  - PORESETn pulsed during a data phase -> all outputs return to 0.
